rate_detector: RTL and testbench
================================

RATE_DETECTOR -- requirements
Module: rate_detector

Interface
REQ-001 The block SHALL expose parameter CLOCK_FREQUENCY, default 500, giving the base period in ClockIn cycles for Speed code 01.
REQ-002 The block SHALL have port ClockIn, input, 1 bit, the single clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port PulseIn, input, 1 bit, the rate-enable stream to be decoded, synchronous to ClockIn; each cycle sampled high counts as one pulse.
REQ-005 The block SHALL have port SpeedOut, output, 2 bits, the decoded speed code, valid only while Valid=1.
REQ-006 The block SHALL have port Valid, output, 1 bit, high while the detector is locked to a legal rate.
REQ-007 The block SHALL have port Error, output, 1 bit, a one-cycle pulse on any illegal period or loss of lock.
REQ-008 The block SHALL have port PulseCount, output, 4 bits, a count of pulses received while locked.

Function
REQ-009 Period P SHALL be the number of ClockIn cycles from one sampled pulse to the next; pulses on consecutive cycles give P=1.
REQ-010 Period counter width SHALL be $clog2(4*CLOCK_FREQUENCY)+1 bits.
REQ-011 The period counter SHALL saturate at 4*CLOCK_FREQUENCY+1 and never wrap.
REQ-012 Legal periods and codes SHALL be exact matches only: P=1 gives 00, P=CF gives 01, P=2*CF gives 10, P=4*CF gives 11; any other P is illegal.
REQ-013 The FSM SHALL have states IDLE, MEASURE, CONFIRM and LOCKED.
REQ-014 IDLE: on the first pulse, the FSM SHALL clear the counter and go to MEASURE; it SHALL produce no Error.
REQ-015 MEASURE: on a pulse with a legal P, the FSM SHALL store the code as the candidate and go to CONFIRM; on a pulse with an illegal P, it SHALL pulse Error and stay in MEASURE.
REQ-016 CONFIRM: on a pulse with P legal and equal to the candidate, the FSM SHALL go to LOCKED.
REQ-017 CONFIRM: on a pulse with P legal but different, the FSM SHALL replace the candidate and stay in CONFIRM; on a pulse with an illegal P, it SHALL pulse Error and go to MEASURE.
REQ-018 LOCKED: on a pulse with P equal to the locked code, the FSM SHALL stay in LOCKED and increment PulseCount.
REQ-019 LOCKED: on any other pulse, the FSM SHALL pulse Error, drop Valid and go to MEASURE.
REQ-020 Timeout: when the counter reaches saturation with no pulse, MEASURE, CONFIRM and LOCKED SHALL go to IDLE and drop Valid; Error SHALL pulse only if the state was LOCKED.
REQ-021 In every state, the counter SHALL restart at 1 on the cycle after each sampled pulse.
REQ-022 Outputs SHALL be registered; Valid and SpeedOut update on the clock edge that samples the confirming pulse, becoming visible the following cycle.
REQ-023 Lock latency SHALL be two full matching periods after the first pulse, plus 1 cycle.
REQ-024 PulseCount SHALL wrap from 15 to 0 and SHALL clear to 0 on entry to LOCKED.
REQ-025 PulseCount SHALL hold its value while not locked.
REQ-026 SpeedOut SHALL hold its last locked value when Valid=0.
REQ-027 A pulse coinciding with saturation SHALL be treated as a pulse with an illegal P, not as a timeout.
REQ-028 A continuous-high PulseIn SHALL lock to code 00 three cycles after its first sampled high.

Reset
REQ-029 While Reset=0, state SHALL be IDLE, with counter, SpeedOut, Valid, Error and PulseCount all 0, regardless of ClockIn.
REQ-030 Assertion mid-operation SHALL abort the measurement immediately.
REQ-031 After deassertion, the first PulseIn sampled high SHALL be treated as the IDLE first pulse.

Verification (CLOCK_FREQUENCY=4)
REQ-032 Pulses every 4 cycles after reset SHALL give Valid=1 and SpeedOut=01 one cycle after the third pulse, with Error never asserted.
REQ-033 Pulses every 8 cycles, then every 16 cycles, SHALL give a lock at 10, then one Error pulse with Valid=0 at the first 16-period, then a lock at 11 after two more 16-periods.
REQ-034 PulseIn held high SHALL give Valid=1 and SpeedOut=00 by the 4th cycle, with PulseCount counting 1 to 15, then 0, then 1 on successive cycles.
REQ-035 Pulses every 5 cycles SHALL give an Error pulse at every pulse after the first, and Valid SHALL stay 0.
REQ-036 Locked at 01 with PulseIn then held low SHALL give Error for one cycle and Valid=0 exactly 17 cycles after the last pulse, and the state SHALL return to IDLE.
REQ-037 Reset pulled low mid-CONFIRM, asynchronously between edges, SHALL immediately give all outputs 0, and a relock after release SHALL require three fresh pulses.

Source files
------------

// File: rtl/rate_detector_if.sv
`default_nettype none
// ============================================================================
// Module      : rate_detector_if
// Description : Pulse stream and decoded-rate status bundle for rate_detector.
// Revision    : 1.0 - initial release
// ============================================================================

interface rate_detector_if;
    logic       PulseIn;
    logic [1:0] SpeedOut;
    logic       Valid;
    logic       Error;
    logic [3:0] PulseCount;

    // master sources the pulse stream, slave is the detector
    modport master (
        output PulseIn,
        input  SpeedOut,
        input  Valid,
        input  Error,
        input  PulseCount
    );

    modport slave (
        input  PulseIn,
        output SpeedOut,
        output Valid,
        output Error,
        output PulseCount
    );
endinterface

`default_nettype wire

// File: rtl/rate_detector.sv
`default_nettype none
// ============================================================================
// Module      : rate_detector
// Description : Measures the spacing of PulseIn and locks onto one of four
//               exact legal rates after two matching periods.
// Revision    : 1.0 - initial release
// ============================================================================

module rate_detector #(
    parameter int CLOCK_FREQUENCY = 500
) (
    input wire             ClockIn,
    input wire             Reset,
    rate_detector_if.slave bus
);

    localparam int c_CW = $clog2(4 * CLOCK_FREQUENCY) + 1;

    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);
    localparam logic [c_CW-1:0] c_PCF1 = c_CW'(CLOCK_FREQUENCY);
    localparam logic [c_CW-1:0] c_PCF2 = c_CW'(2 * CLOCK_FREQUENCY);
    localparam logic [c_CW-1:0] c_PCF4 = c_CW'(4 * CLOCK_FREQUENCY);
    localparam logic [c_CW-1:0] c_SAT  = c_CW'(4 * CLOCK_FREQUENCY + 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_MEASURE = 2'd1;
    localparam logic [1:0] c_CONFIRM = 2'd2;
    localparam logic [1:0] c_LOCKED  = 2'd3;

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [1:0]      r_cand;
    logic [1:0]      r_speed;
    logic            r_valid;
    logic            r_err;
    logic [3:0]      r_pcnt;

    logic [1:0]      w_state_nx;
    logic [c_CW-1:0] w_cnt_nx;
    logic [1:0]      w_cand_nx;
    logic [1:0]      w_speed_nx;
    logic            w_valid_nx;
    logic            w_err_nx;
    logic [3:0]      w_pcnt_nx;
    logic            w_legal;
    logic [1:0]      w_code;
    logic            w_timeout;

    // r_cnt holds the current period; a saturated count never matches a legal rate
    always_comb begin
        w_legal = 1'b1;
        w_code  = 2'b00;
        if (r_cnt == c_ONE) begin
            w_code = 2'b00;
        end else if (r_cnt == c_PCF1) begin
            w_code = 2'b01;
        end else if (r_cnt == c_PCF2) begin
            w_code = 2'b10;
        end else if (r_cnt == c_PCF4) begin
            w_code = 2'b11;
        end else begin
            w_legal = 1'b0;
        end
    end

    assign w_timeout = !bus.PulseIn && (r_cnt == c_SAT);

    always_comb begin
        if (bus.PulseIn) begin
            w_cnt_nx = c_ONE;
        end else if (r_cnt == c_SAT) begin
            w_cnt_nx = r_cnt;
        end else begin
            w_cnt_nx = r_cnt + c_ONE;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cand_nx  = r_cand;
        w_speed_nx = r_speed;
        w_valid_nx = r_valid;
        w_err_nx   = 1'b0;
        w_pcnt_nx  = r_pcnt;

        case (r_state)
            c_IDLE: begin
                if (bus.PulseIn) begin
                    w_state_nx = c_MEASURE;
                end
            end

            c_MEASURE: begin
                if (bus.PulseIn) begin
                    if (w_legal) begin
                        w_cand_nx  = w_code;
                        w_state_nx = c_CONFIRM;
                    end else begin
                        w_err_nx = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nx = c_IDLE;
                end
            end

            c_CONFIRM: begin
                if (bus.PulseIn) begin
                    if (!w_legal) begin
                        w_err_nx   = 1'b1;
                        w_state_nx = c_MEASURE;
                    end else if (w_code == r_cand) begin
                        w_state_nx = c_LOCKED;
                        w_valid_nx = 1'b1;
                        w_speed_nx = w_code;
                        w_pcnt_nx  = 4'd0;
                    end else begin
                        w_cand_nx = w_code;
                    end
                end else if (w_timeout) begin
                    w_state_nx = c_IDLE;
                end
            end

            c_LOCKED: begin
                if (bus.PulseIn) begin
                    if (w_legal && (w_code == r_speed)) begin
                        w_pcnt_nx = r_pcnt + 4'd1;
                    end else begin
                        w_err_nx   = 1'b1;
                        w_valid_nx = 1'b0;
                        w_state_nx = c_MEASURE;
                    end
                end else if (w_timeout) begin
                    w_err_nx   = 1'b1;
                    w_valid_nx = 1'b0;
                    w_state_nx = c_IDLE;
                end
            end

            default: begin
                w_state_nx = c_IDLE;
                w_valid_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ClockIn or negedge Reset) begin
        if (!Reset) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_cand  <= 2'b00;
            r_speed <= 2'b00;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_pcnt  <= 4'd0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_cand  <= w_cand_nx;
            r_speed <= w_speed_nx;
            r_valid <= w_valid_nx;
            r_err   <= w_err_nx;
            r_pcnt  <= w_pcnt_nx;
        end
    end

    assign bus.SpeedOut   = r_speed;
    assign bus.Valid      = r_valid;
    assign bus.Error      = r_err;
    assign bus.PulseCount = r_pcnt;

endmodule

`default_nettype wire

// File: tb/tb_rate_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_rate_detector
// Description : Self-checking bench for rate_detector with CLOCK_FREQUENCY=4.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_rate_detector;

    logic clk;
    logic rst_n;

    rate_detector_if bus ();

    rate_detector #(
        .CLOCK_FREQUENCY(4)
    ) dut (
        .ClockIn(clk),
        .Reset  (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    // expected {Valid, SpeedOut, Error, PulseCount} after each driven cycle
    logic [7:0] exp_q[$];
    string      tag_q[$];

    logic       x_valid;
    logic [1:0] x_speed;
    logic       x_err;
    logic [3:0] x_pcnt;
    string      x_tag;

    function automatic logic [7:0] obs();
        return {bus.Valid, bus.SpeedOut, bus.Error, bus.PulseCount};
    endfunction

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got V/S/E/C=%b/%b/%b/%0d exp V/S/E/C=%b/%b/%b/%0d",
                     tag, $time, got[7], got[6:5], got[4], got[3:0],
                     exp[7], exp[6:5], exp[4], exp[3:0]);
        end
    endtask

    task automatic pop_check();
        logic [7:0] e;
        string      t;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_eq(t, obs(), e);
        end
    endtask

    // one clock: settle previous expectation, drive PulseIn, queue the result
    task automatic step(input logic p);
        @(negedge clk);
        pop_check();
        bus.PulseIn = p;
        exp_q.push_back({x_valid, x_speed, x_err, x_pcnt});
        tag_q.push_back(x_tag);
        x_err = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        pop_check();
        bus.PulseIn = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_eq("rst_async", obs(), 8'h00);
        x_valid = 1'b0;
        x_speed = 2'b00;
        x_err   = 1'b0;
        x_pcnt  = 4'd0;
        repeat (2) begin
            @(negedge clk);
            check_eq("rst_hold", obs(), 8'h00);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b1;
        bus.PulseIn = 1'b0;
        x_valid     = 1'b0;
        x_speed     = 2'b00;
        x_err       = 1'b0;
        x_pcnt      = 4'd0;
        x_tag       = "reset";
        do_reset();

        // period 4 -> lock 01 on third pulse, then 17-cycle timeout
        x_tag = "per4";
        for (int k = 0; k < 6; k++) begin
            if (k == 2) begin
                x_valid = 1'b1;
                x_speed = 2'b01;
                x_pcnt  = 4'd0;
            end else if (k > 2) begin
                x_pcnt = x_pcnt + 4'd1;
            end
            step(1'b1);
            idle(3);
        end
        x_tag = "timeout";
        idle(13);
        x_err   = 1'b1;
        x_valid = 1'b0;
        step(1'b0);
        idle(3);

        // period 8 lock 10, then period 16 -> error, relock 11
        x_tag = "per8";
        step(1'b1);
        for (int k = 1; k < 4; k++) begin
            idle(7);
            if (k == 2) begin
                x_valid = 1'b1;
                x_speed = 2'b10;
                x_pcnt  = 4'd0;
            end else if (k == 3) begin
                x_pcnt = x_pcnt + 4'd1;
            end
            step(1'b1);
        end
        x_tag = "per16";
        for (int k = 0; k < 4; k++) begin
            idle(15);
            if (k == 0) begin
                x_err   = 1'b1;
                x_valid = 1'b0;
            end else if (k == 2) begin
                x_valid = 1'b1;
                x_speed = 2'b11;
                x_pcnt  = 4'd0;
            end else if (k == 3) begin
                x_pcnt = x_pcnt + 4'd1;
            end
            step(1'b1);
        end
        idle(2);

        // continuous high -> lock 00, PulseCount wraps 15 -> 0
        do_reset();
        x_tag = "cont";
        for (int c = 0; c < 20; c++) begin
            if (c == 2) begin
                x_valid = 1'b1;
                x_speed = 2'b00;
                x_pcnt  = 4'd0;
            end else if (c > 2) begin
                x_pcnt = x_pcnt + 4'd1;
            end
            step(1'b1);
        end
        x_tag = "cont_end";
        step(1'b0);

        // period 5 is illegal: error at every pulse after the first
        do_reset();
        x_tag = "per5";
        step(1'b1);
        for (int k = 1; k < 5; k++) begin
            idle(4);
            x_err = 1'b1;
            step(1'b1);
        end
        idle(2);

        // pulse exactly at saturation counts as illegal, not a timeout
        do_reset();
        x_tag = "sat";
        step(1'b1);
        idle(16);
        x_err = 1'b1;
        step(1'b1);
        idle(3);
        step(1'b1);
        idle(3);
        x_valid = 1'b1;
        x_speed = 2'b01;
        x_pcnt  = 4'd0;
        step(1'b1);
        idle(3);
        x_pcnt = 4'd1;
        step(1'b1);

        // lose lock, reach CONFIRM, reset asynchronously, relock from scratch
        x_tag = "confirm_rst";
        idle(7);
        x_err   = 1'b1;
        x_valid = 1'b0;
        step(1'b1);
        idle(7);
        step(1'b1);
        idle(3);
        do_reset();
        x_tag = "relock";
        step(1'b1);
        idle(7);
        step(1'b1);
        idle(7);
        x_valid = 1'b1;
        x_speed = 2'b10;
        x_pcnt  = 4'd0;
        step(1'b1);
        idle(2);

        @(negedge clk);
        pop_check();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
